gen_poly_osc: RTL

GEN_POLY_OSC -- requirements
Module: gen_poly_osc

---
 rtl/gen_poly_osc.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gen_poly_osc.sv
// Multi-channel phase-accumulator oscillator: one sample frame every DIV clocks,
// channels are rendered serially, scaled by gain, mixed and saturated to 16 bits.
module gen_poly_osc #(
    parameter int NCH = 4,
    parameter int PW  = 24,
    parameter int DIV = 1000
) (
    input  logic                                 i_clk48,
    input  logic                                 i_rst48,
    input  logic                                 i_pause,
    input  logic                                 i_cfg_we,
    input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] i_cfg_ch,
    input  logic [PW-1:0]                        i_cfg_inc,
    input  logic [2:0]                           i_cfg_wave,
    input  logic [7:0]                           i_cfg_duty,
    input  logic [7:0]                           i_cfg_gain,
    input  logic                                 i_cfg_sync,
    output logic signed [15:0]                   o_sample,
    output logic                                 o_valid,
    output logic                                 o_busy
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = 24 + $clog2(NCH);
    localparam int NW = $clog2(DIV);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MIX, S_OUT} state_t;

    state_t                r_state;
    logic [NW-1:0]         r_cnt;
    logic [CW-1:0]         r_ch;
    logic [PW-1:0]         r_phase [NCH];
    logic [PW-1:0]         r_inc   [NCH];
    logic [2:0]            r_wave  [NCH];
    logic [7:0]            r_duty  [NCH];
    logic [7:0]            r_gain  [NCH];
    logic [15:0]           r_lfsr;
    logic signed [AW-1:0]  r_acc;
    logic signed [15:0]    r_sample;
    logic                  r_valid;
    logic                  r_busy;

    logic                  w_tick;
    logic [15:0]           w_p;
    logic [15:0]           w_t;
    logic [15:0]           w_s;
    logic signed [15:0]    w_wave;
    logic signed [24:0]    w_prod;
    logic signed [AW-9:0]  w_shift;
    logic signed [15:0]    w_sat;

    // Half-wave parabola x*(32767-x)/8192, returned in offset-binary like the saw.
    function automatic logic [15:0] saw2sin(input logic [15:0] p);
        logic [14:0] x;
        logic [14:0] y;
        x = p[14:0];
        y = 15'((30'(x) * 30'(15'h7FFF - x)) >> 13);
        return p[15] ? {1'b0, 15'h7FFF - y} : {1'b1, y};
    endfunction

    assign w_tick = (r_cnt == NW'(DIV - 1));
    assign w_p    = r_phase[r_ch][PW-1:PW-16];
    assign w_t    = w_p[15] ? {~w_p[14:0], 1'b1} : {w_p[14:0], 1'b0};
    assign w_s    = saw2sin(w_p);

    always_comb begin
        w_wave = '0;
        case (r_wave[r_ch])
            3'd0:    w_wave = {~w_p[15], w_p[14:0]};
            3'd1:    w_wave = (w_p[15:8] < r_duty[r_ch]) ? 16'sh7FFF : 16'sh8000;
            3'd2:    w_wave = {~w_t[15], w_t[14:0]};
            3'd3:    w_wave = {~w_s[15], w_s[14:0]};
            3'd4:    w_wave = r_lfsr;
            default: w_wave = '0;
        endcase
    end

    assign w_prod  = 25'(w_wave) * 25'($signed({1'b0, r_gain[r_ch]}));
    assign w_shift = (AW-8)'(r_acc >>> 8);
    assign w_sat   = (w_shift > $signed((AW-8)'(32767)))  ? 16'sh7FFF :
                     (w_shift < $signed((AW-8)'(-32768))) ? 16'sh8000 : w_shift[15:0];

    // Frame sequencing, mixing and registered outputs.
    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ch     <= '0;
            r_lfsr   <= 16'hACE1;
            r_acc    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state <= S_RUN;
                        r_ch    <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc <= r_acc + AW'(w_prod);
                    if (r_ch == CW'(NCH - 1)) r_state <= S_MIX;
                    else                      r_ch    <= r_ch + 1'b1;
                end
                S_MIX: begin
                    r_sample <= w_sat;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_OUT;
                end
                S_OUT: begin
                    if (!i_pause)
                        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Channel state; a sync write is placed last so it overrides the phase step.
    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            for (int k = 0; k < NCH; k++) begin
                r_phase[k] <= '0;
                r_inc[k]   <= '0;
                r_wave[k]  <= 3'd5;
                r_duty[k]  <= 8'd128;
                r_gain[k]  <= 8'd0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (r_state == S_RUN && r_ch == CW'(k) && !i_pause)
                    r_phase[k] <= r_phase[k] + r_inc[k];
                if (i_cfg_we && i_cfg_ch == CW'(k)) begin
                    r_inc[k]  <= i_cfg_inc;
                    r_wave[k] <= i_cfg_wave;
                    r_duty[k] <= i_cfg_duty;
                    r_gain[k] <= i_cfg_gain;
                    if (i_cfg_sync) r_phase[k] <= '0;
                end
            end
        end
    end

    assign o_sample = r_sample;
    assign o_valid  = r_valid;
    assign o_busy   = r_busy;

endmodule
